// File: rtl/mcycle_unit_if.sv
// rtl/mcycle_unit_if.sv - decoder-side request/result bundle for the multiply/divide unit
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy
    );
endinterface

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// Optional MCYCLE_EARLY_TERM_EN: multiply finishes once the remaining multiplier bits are zero.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input logic         CLK,
    input logic         RESETn,
    mcycle_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, COMPUTING} state_t;

    state_t             state, nextState;
    logic [1:0]         opReg;
    logic               signA, signB;
    logic [WIDTH-1:0]   opB;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   res1, res2;

    logic               reqSigned, reqNegA, reqNegB;
    logic [WIDTH-1:0]   reqMagA, reqMagB;

    always_comb begin
        reqSigned = ~bus.MCycleOp[0];
        reqNegA   = reqSigned & bus.Operand1[WIDTH-1];
        reqNegB   = reqSigned & bus.Operand2[WIDTH-1];
        reqMagA   = reqNegA ? -bus.Operand1 : bus.Operand1;
        reqMagB   = reqNegB ? -bus.Operand2 : bus.Operand2;
    end

    // Multiply: opB shifts right, mcand shifts left. Divide: opB is the fixed divisor.
    logic               isDiv, isSigned, lastIter, doneIter, divByZero;
    logic               negQuot, negRem;
    logic [2*WIDTH-1:0] mulAcc, divAcc, iterAcc, product;
    logic [WIDTH:0]     divTop, divDiff;
    logic               divGe;
    logic [WIDTH-1:0]   quot, rem, finalR1, finalR2;

    always_comb begin
        isDiv    = opReg[1];
        isSigned = ~opReg[0];
        mulAcc   = acc + (opB[0] ? mcand : '0);
        divTop   = acc[2*WIDTH-1:WIDTH-1];
        divGe    = divTop >= {1'b0, opB};
        divDiff  = divTop - {1'b0, opB};
        divAcc   = divGe ? {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                         : {divTop[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
        iterAcc  = isDiv ? divAcc : mulAcc;
        lastIter = count == CW'(WIDTH - 1);
`ifdef MCYCLE_EARLY_TERM_EN
        doneIter = lastIter | (~isDiv & (opB == '0));
`else
        doneIter = lastIter;
`endif
        negQuot   = isSigned & (signA ^ signB);
        negRem    = isSigned & signA;
        divByZero = opB == '0;
        product   = negQuot ? -mulAcc : mulAcc;
        quot      = iterAcc[WIDTH-1:0];
        rem       = iterAcc[2*WIDTH-1:WIDTH];
        if (isDiv) begin
            // Zero divisor leaves the dividend magnitude as remainder; only the quotient needs forcing.
            finalR1 = divByZero ? '1 : (negQuot ? -quot : quot);
            finalR2 = negRem ? -rem : rem;
        end else begin
            finalR1 = product[WIDTH-1:0];
            finalR2 = product[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        bus.Busy  = 1'b0;
        case (state)
            IDLE: begin
                bus.Busy = bus.Start;
                if (bus.Start) nextState = COMPUTING;
            end
            COMPUTING: begin
                bus.Busy = 1'b1;
                if (doneIter) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            opReg <= '0;
            signA <= 1'b0;
            signB <= 1'b0;
            opB   <= '0;
            acc   <= '0;
            mcand <= '0;
            count <= '0;
            res1  <= '0;
            res2  <= '0;
        end else if (state == IDLE) begin
            if (bus.Start) begin
                opReg <= bus.MCycleOp;
                signA <= bus.Operand1[WIDTH-1];
                signB <= bus.Operand2[WIDTH-1];
                opB   <= reqMagB;
                acc   <= bus.MCycleOp[1] ? {{WIDTH{1'b0}}, reqMagA} : '0;
                mcand <= {{WIDTH{1'b0}}, reqMagA};
                count <= '0;
            end
        end else begin
            acc   <= iterAcc;
            mcand <= mcand << 1;
            opB   <= isDiv ? opB : (opB >> 1);
            count <= count + CW'(1);
            if (doneIter) begin
                res1 <= finalR1;
                res2 <= finalR2;
            end
        end
    end

    assign bus.Result1 = res1;
    assign bus.Result2 = res2;
endmodule
